// File: rtl/alu_multicycle.sv
// Multi-cycle ALU with enable/busy/done handshake; MUL/DIV/MOD run bit-serially over WIDTH steps.
// IDLE | accepting ops, single-cycle results written here ; ITER | iterative op, one step per edge
module alu_multicycle #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A_bus,
  input  logic [WIDTH-1:0] B_bus,
  input  logic [3:0]       Control,
  input  logic             enable,
  output logic [WIDTH-1:0] C_bus,
  output logic             Z_flag,
  output logic             DZ_flag,
  output logic             OV_flag,
  output logic             busy,
  output logic             done
);

  localparam logic [3:0] OP_ADD   = 4'b0001;
  localparam logic [3:0] OP_SUB   = 4'b0010;
  localparam logic [3:0] OP_MUL   = 4'b0011;
  localparam logic [3:0] OP_MOD   = 4'b0100;
  localparam logic [3:0] OP_PASSA = 4'b0101;
  localparam logic [3:0] OP_PASSB = 4'b0110;
  localparam logic [3:0] OP_INC   = 4'b0111;
  localparam logic [3:0] OP_DEC   = 4'b1000;
  localparam logic [3:0] OP_RST   = 4'b1001;
  localparam logic [3:0] OP_DIV   = 4'b1010;

  typedef enum logic {S_IDLE, S_ITER} state_t;

  state_t           state_q;
  logic [3:0]       op_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] hi_q, lo_q, opnd_q;
  logic [WIDTH-1:0] c_q;
  logic             z_q, dz_q, ov_q, busy_q, done_q;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] hi_d, lo_d;
  logic [WIDTH-1:0] it_res;
  logic             opnd_zero;
  logic [WIDTH-1:0] sc_res;
  logic             sc_wr;
  logic             is_iter;

  // MUL: {hi,lo} is the product shifting right, lo starts as B, opnd is A.
  // DIV/MOD: hi is the partial remainder, lo shifts the dividend out and the quotient in, opnd is B.
  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = {hi_q, lo_q[WIDTH-1]};
    div_ge    = div_shift >= {1'b0, opnd_q};
    hi_d      = hi_q;
    lo_d      = lo_q;
    if (op_q == OP_MUL) begin
      hi_d = mul_sum[WIDTH:1];
      lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
    end else begin
      hi_d = div_ge ? (div_shift[WIDTH-1:0] - opnd_q) : div_shift[WIDTH-1:0];
      lo_d = {lo_q[WIDTH-2:0], div_ge};
    end
  end

  always_comb begin
    opnd_zero = (opnd_q == '0);
    case (op_q)
      OP_DIV:  it_res = opnd_zero ? '1 : lo_d;
      OP_MOD:  it_res = opnd_zero ? '0 : hi_d;
      default: it_res = lo_d;
    endcase
  end

  always_comb begin
    sc_res  = c_q;
    sc_wr   = 1'b1;
    is_iter = 1'b0;
    case (Control)
      OP_ADD:   sc_res = A_bus + B_bus;
      OP_SUB:   sc_res = A_bus - B_bus;
      OP_PASSA: sc_res = A_bus;
      OP_PASSB: sc_res = B_bus;
      OP_INC:   sc_res = A_bus + WIDTH'(1);
      OP_DEC:   sc_res = A_bus - WIDTH'(1);
      OP_RST:   sc_res = '0;
      OP_MUL, OP_DIV, OP_MOD: begin
        sc_wr   = 1'b0;
        is_iter = 1'b1;
      end
      default:  sc_wr = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      opnd_q  <= '0;
      c_q     <= '0;
      z_q     <= 1'b0;
      dz_q    <= 1'b0;
      ov_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (enable) begin
            op_q <= Control;
            if (is_iter) begin
              state_q <= S_ITER;
              busy_q  <= 1'b1;
              cnt_q   <= CNT_W'(WIDTH);
              hi_q    <= '0;
              opnd_q  <= (Control == OP_MUL) ? A_bus : B_bus;
              lo_q    <= (Control == OP_MUL) ? B_bus : A_bus;
            end else begin
              done_q <= 1'b1;
              if (sc_wr) begin
                c_q <= sc_res;
                z_q <= (sc_res == '0);
              end
            end
          end
        end
        S_ITER: begin
          hi_q  <= hi_d;
          lo_q  <= lo_d;
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            c_q     <= it_res;
            z_q     <= (it_res == '0);
            if (op_q == OP_MUL) ov_q <= |hi_d;
            else                dz_q <= opnd_zero;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign C_bus   = c_q;
  assign Z_flag  = z_q;
  assign DZ_flag = dz_q;
  assign OV_flag = ov_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule
